wb_master_if: RTL and testbench
===============================

Name: wb_master_if

Overview:
- Wishbone classic-cycle initiator between the CPU memory stage and the system Wishbone bus.
- Converts a single load/store request into one Wishbone read or write cycle and returns read data.
- Raises a pipeline stall request while the cycle is outstanding.
- Handles pipeline stall/flush interaction, slave error and a no-response timeout; drives peripheral slaves such as the timer/interrupt controller and memories.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte lanes = DW/8).
- TIMEOUT, 255, cycles in BUSY without ack/err before abort; 0 disables.
- TW, 8, timeout counter width; TIMEOUT must fit in TW bits.

Ports:
- wb_clk_i  in  1  clock, all state on rising edge
- wb_rst_i  in  1  asynchronous, active-low reset
- cpu_ce_i  in  1  memory-stage request valid
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  AW  request address
- cpu_data_i  in  DW  store data
- cpu_sel_i  in  DW/8  byte enables
- cpu_stall_i  in  1  pipeline stage after memory is stalled
- flush_i  in  1  pipeline flush (trap/interrupt)
- cpu_data_o  out  DW  load data to pipeline
- stallreq_o  out  1  hold pipeline
- bus_err_o  out  1  one-cycle pulse: slave err or timeout
- wb_adr_o  out  AW  Wishbone address
- wb_dat_o  out  DW  Wishbone write data
- wb_dat_i  in  DW  Wishbone read data
- wb_sel_o  out  DW/8  byte select
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error

Behaviour:
- Reset (wb_rst_i=0, async):
  - state=IDLE; timeout counter and read buffer 0.
  - wb_cyc_o/stb_o/we_o=0; wb_adr_o/dat_o/sel_o=0; bus_err_o=0.
  - Combinational outputs: stallreq_o=0, cpu_data_o=0.
- Registered outputs: all wb_*_o and bus_err_o. Combinational outputs: stallreq_o and cpu_data_o.
- IDLE:
  - cpu_ce_i=1 and flush_i=0 → at the next edge latch adr/dat/sel/we, set cyc=stb=1, clear counter, go BUSY.
  - stallreq_o = cpu_ce_i & ~flush_i.
  - cpu_data_o = 0.
  - wb_ack_i/wb_err_i in IDLE are ignored; a slave with a registered ack may hold ack one cycle past the cycle.
- BUSY:
  - cyc=stb=1; address, data, sel and we held stable.
  - Counter increments each cycle.
  - stallreq_o = ~(wb_ack_i | wb_err_i).
  - Priority at each edge: flush_i > wb_err_i > wb_ack_i > timeout.
  - flush_i=1: drop cyc/stb, go IDLE, no error, no data returned; an ack arriving in that same cycle is discarded.
  - wb_err_i=1: drop cyc/stb, bus_err_o=1 for one cycle, go IDLE.
  - wb_ack_i=1 on a read: cpu_data_o = wb_dat_i in the same cycle, and wb_dat_i is captured into the read buffer.
  - wb_ack_i=1 on a write: cpu_data_o = 0.
  - wb_ack_i=1, next state: cyc/stb drop at the edge; go WAIT_FOR_STALL if cpu_stall_i=1, else IDLE.
  - Timeout (TIMEOUT≠0, counter = TIMEOUT-1 with no ack/err):
    - stallreq_o stays 1 that cycle.
    - At the edge: drop cyc/stb, bus_err_o pulse, go IDLE.
    - The pipeline retains the request; it is reissued only if cpu_ce_i is still 1.
- WAIT_FOR_STALL:
  - Bus idle; stallreq_o=0.
  - cpu_data_o = read buffer (0 after a write).
  - Go IDLE when cpu_stall_i=0 or flush_i=1.
- Minimum latency with a combinational-ack slave:
  - Request in cycle N; cyc high in N+1; ack in N+1; stallreq_o low in N+1.
  - Registered-ack slave: ack in N+2.
- One outstanding cycle only; no pipelined or burst transfers.
- wb_stb_o == wb_cyc_o at all times.
- Reset mid-cycle aborts immediately; cyc drops asynchronously.

Decomposition:
- defines.v:
  - State encodings: WB_IDLE=2'b00, WB_BUSY=2'b01, WB_WAIT_FOR_STALL=2'b11.
  - Widths and constants: RegBus, ZeroWord, default timeout constant.
- Single module; no sub-module (the timeout counter is one always block).

Test Plan:
- Read, registered-ack slave returning 0x0000_1234 at 0x0200_BFF8, cpu_stall_i=0:
  - cyc/stb high for exactly 2 cycles; stallreq_o high for 2 cycles.
  - cpu_data_o=0x0000_1234 in the ack cycle; a trailing ack in IDLE causes no second cycle.
- Write 0x0000_0001, sel=4'hF, to 0x0200_0000:
  - wb_we_o=1; wb_dat_o=0x0000_0001 and wb_adr_o=0x0200_0000 stable until ack.
  - Then IDLE; bus_err_o stays 0.
- Read acked with cpu_stall_i=1 for 3 cycles, data 0xDEAD_BEEF:
  - State is WAIT_FOR_STALL.
  - cpu_data_o=0xDEAD_BEEF and stallreq_o=0 for all 3 cycles; IDLE after cpu_stall_i falls.
- flush_i=1 during BUSY:
  - cyc/stb drop at the next edge; state IDLE; bus_err_o=0.
  - A late ack one cycle later is ignored.
- Slave never acks, TIMEOUT=255:
  - cyc stays high exactly 255 cycles, then drops; one bus_err_o pulse.
  - wb_err_i asserted on a separate read gives the same pulse and abort.
- wb_rst_i pulled low mid-BUSY between clock edges:
  - wb_cyc_o/wb_stb_o/stallreq_o go 0 immediately.
  - After release the block is in IDLE and a new request completes normally.

Source files
------------

// File: rtl/wb_master_if_pkg.sv
// Shared state encodings and bus-width constants for the Wishbone initiator.
package wb_master_if_pkg;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_WAIT_FOR_STALL = 2'b11
  } wb_state_e;

  localparam int                RegBus       = 32;
  localparam logic [RegBus-1:0] ZeroWord     = '0;
  localparam int                WbTimeoutDef = 255;

endpackage

// File: rtl/wb_master_if.sv
// Wishbone classic-cycle initiator: one CPU load/store becomes one bus cycle,
// with pipeline stall, flush, slave error and no-response timeout handling.
module wb_master_if
  import wb_master_if_pkg::*;
#(
  parameter int AW      = RegBus,
  parameter int DW      = RegBus,
  parameter int TIMEOUT = WbTimeoutDef,
  parameter int TW      = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [AW-1:0]     cpu_addr_i,
  input  logic [DW-1:0]     cpu_data_i,
  input  logic [DW/8-1:0]   cpu_sel_i,
  input  logic              cpu_stall_i,
  input  logic              flush_i,
  output logic [DW-1:0]     cpu_data_o,
  output logic              stallreq_o,
  output logic              bus_err_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  // Counter value seen in the last BUSY cycle before the timeout abort.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  wb_state_e     r_state, w_state_nxt;
  logic [TW-1:0] r_cnt;
  logic [DW-1:0] r_rd_buf;
  logic          w_start, w_timeout, w_bus_err, w_ack_ok;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_state <= WB_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stallreq_o  = 1'b0;
    cpu_data_o  = '0;
    w_bus_err   = 1'b0;
    w_start     = 1'b0;
    w_ack_ok    = 1'b0;
    w_timeout   = (TIMEOUT != 0) && (r_cnt == TO_LAST) && !wb_ack_i && !wb_err_i;
    case (r_state)
      WB_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          w_start     = 1'b1;
          w_state_nxt = WB_BUSY;
        end
      end
      WB_BUSY: begin
        stallreq_o = ~(wb_ack_i | wb_err_i);
        // Flush wins over everything, including a same-cycle ack.
        if (flush_i) begin
          w_state_nxt = WB_IDLE;
        end else if (wb_err_i) begin
          w_state_nxt = WB_IDLE;
          w_bus_err   = 1'b1;
        end else if (wb_ack_i) begin
          w_ack_ok    = 1'b1;
          if (!wb_we_o) cpu_data_o = wb_dat_i;
          w_state_nxt = cpu_stall_i ? WB_WAIT_FOR_STALL : WB_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = WB_IDLE;
          w_bus_err   = 1'b1;
        end
      end
      WB_WAIT_FOR_STALL: begin
        cpu_data_o = r_rd_buf;
        if (!cpu_stall_i || flush_i) w_state_nxt = WB_IDLE;
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      bus_err_o <= 1'b0;
      r_cnt     <= '0;
      r_rd_buf  <= '0;
    end else begin
      bus_err_o <= w_bus_err;
      if (w_start) begin
        wb_adr_o <= cpu_addr_i;
        wb_dat_o <= cpu_data_i;
        wb_sel_o <= cpu_sel_i;
        wb_we_o  <= cpu_we_i;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        r_cnt    <= '0;
      end else if (r_state == WB_BUSY) begin
        r_cnt <= r_cnt + TW'(1);
        if (w_state_nxt != WB_BUSY) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
        // Writes leave zero behind so a stalled store presents no data.
        if (w_ack_ok) r_rd_buf <= wb_we_o ? '0 : wb_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_if.sv
// Randomized scoreboard bench for wb_master_if with a behavioural memory slave.
module tb_wb_master_if;

  localparam int TIMEOUT = 255;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cpu_ce_i, cpu_we_i, cpu_stall_i, flush_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  logic        stallreq_o, bus_err_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic        wb_ack_i, wb_err_i;
  logic        s_ack = 1'b0, s_err = 1'b0, f_ack = 1'b0;

  assign wb_ack_i = s_ack | f_ack;
  assign wb_err_i = s_err;

  wb_master_if #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT), .TW(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_stall_i(cpu_stall_i),
    .flush_i(flush_i), .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
    .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct { bit err; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] s_mem   [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_unexp(input string nm);
    n_chk++;
    $display("FAIL %s: got a response, expected none", nm);
  endtask

  // Slave: mode 0 = ack after s_lat cycles, 1 = err after s_lat, 2 = silent.
  int s_mode = 2, s_lat = 0, s_cnt = 0;
  bit s_in = 1'b0;
  always begin
    @(posedge wb_clk_i);
    #1;
    if (wb_cyc_o) begin
      if (!s_in) begin s_in = 1'b1; s_cnt = 0; end
      else s_cnt++;
    end else s_in = 1'b0;
    s_ack = wb_cyc_o && s_mode == 0 && s_cnt == s_lat;
    s_err = wb_cyc_o && s_mode == 1 && s_cnt == s_lat;
    if (s_ack && !wb_we_o)
      wb_dat_i = s_mem.exists(wb_adr_o) ? s_mem[wb_adr_o] : init_word(wb_adr_o);
    else
      wb_dat_i = $urandom;
  end

  always @(negedge wb_clk_i) begin
    if (wb_rst_i && wb_cyc_o && wb_ack_i && !wb_err_i && wb_we_o && !flush_i)
      s_mem[wb_adr_o] = merge(s_mem.exists(wb_adr_o) ? s_mem[wb_adr_o] : init_word(wb_adr_o),
                              wb_dat_o, wb_sel_o);
  end

  // Monitor: pops an expectation whenever the DUT completes or aborts a cycle.
  always @(negedge wb_clk_i) begin : mon
    exp_t e;
    if (wb_rst_i) begin
      chk("stb_eq_cyc", wb_stb_o, wb_cyc_o);
      if (wb_cyc_o && wb_ack_i && !wb_err_i && !flush_i) begin
        if (sb.size() == 0) fail_unexp("ack_rsp");
        else begin
          e = sb.pop_front();
          chk("rsp_is_ack", e.err, 1'b0);
          chk("rd_data", cpu_data_o, e.data);
          chk("ack_stallreq", stallreq_o, 1'b0);
        end
      end
      if (bus_err_o) begin
        if (sb.size() == 0) fail_unexp("err_rsp");
        else begin
          e = sb.pop_front();
          chk("rsp_is_err", e.err, 1'b1);
        end
      end
    end
  end

  task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sel, input int mode, input int lat,
                         input int nstall, input bit trail);
    exp_t e;
    int ncyc, exp_cyc;
    e.err  = (mode != 0);
    e.data = (we || e.err) ? 32'h0 : ref_rd(a);
    if (!e.err && we) ref_mem[a] = merge(ref_rd(a), d, sel);
    exp_cyc = (mode == 2) ? TIMEOUT : lat + 1;
    s_mode = mode; s_lat = lat;
    cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d; cpu_sel_i = sel;
    cpu_stall_i = (nstall > 0);
    cpu_ce_i = 1'b1;
    sb.push_back(e);
    @(negedge wb_clk_i) chk("req_stallreq", stallreq_o, 1'b1);
    @(posedge wb_clk_i); #1;
    cpu_ce_i = 1'b0;
    ncyc = 0;
    while (wb_cyc_o && ncyc < 400) begin
      @(negedge wb_clk_i);
      ncyc++;
      chk("adr_hold", wb_adr_o, a);
      chk("dat_hold", wb_dat_o, d);
      chk("sel_hold", wb_sel_o, sel);
      chk("we_hold", wb_we_o, we);
      chk("busy_stallreq", stallreq_o, !(wb_ack_i || wb_err_i));
      @(posedge wb_clk_i); #1;
    end
    chk("cyc_len", ncyc, exp_cyc);
    if (trail) begin
      f_ack = 1'b1;
      @(negedge wb_clk_i) chk("trail_stallreq", stallreq_o, 1'b0);
      @(posedge wb_clk_i); #1;
      f_ack = 1'b0;
      chk("trail_no_cycle", wb_cyc_o, 1'b0);
    end
    for (int k = 0; k < nstall; k++) begin
      if (k == nstall - 1) cpu_stall_i = 1'b0;
      @(negedge wb_clk_i);
      chk("wait_data", cpu_data_o, e.data);
      chk("wait_stallreq", stallreq_o, 1'b0);
      @(posedge wb_clk_i); #1;
    end
    if (nstall > 0) begin
      @(negedge wb_clk_i) chk("post_wait_idle_data", cpu_data_o, 32'h0);
      @(posedge wb_clk_i); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_data_i = 0; cpu_sel_i = 0;
    cpu_stall_i = 0; flush_i = 0;
    wb_rst_i = 1'b0;
    #12;
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", wb_sel_o, 4'h0);
    chk("rst_bus_err", bus_err_o, 1'b0);
    chk("rst_stallreq", stallreq_o, 1'b0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    @(negedge wb_clk_i); #2;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;

    s_mem[32'h0200_BFF8] = 32'h0000_1234; ref_mem[32'h0200_BFF8] = 32'h0000_1234;
    s_mem[32'h0200_0040] = 32'hDEAD_BEEF; ref_mem[32'h0200_0040] = 32'hDEAD_BEEF;
    run_txn(1'b0, 32'h0200_BFF8, 32'h0, 4'hF, 0, 1, 0, 1'b1);
    run_txn(1'b1, 32'h0200_0000, 32'h0000_0001, 4'hF, 0, 1, 0, 1'b0);
    run_txn(1'b0, 32'h0200_0040, 32'h0, 4'hF, 0, 1, 3, 1'b0);
    run_txn(1'b0, 32'h0200_0000, 32'h0, 4'hF, 0, 0, 0, 1'b0);

    // Flush while BUSY, then a late ack that must be ignored.
    s_mode = 2;
    cpu_we_i = 1'b0; cpu_addr_i = 32'h0200_0010; cpu_ce_i = 1'b1;
    @(posedge wb_clk_i); #1;
    cpu_ce_i = 1'b0; flush_i = 1'b1;
    @(negedge wb_clk_i) chk("flush_busy_stallreq", stallreq_o, 1'b1);
    @(posedge wb_clk_i); #1;
    flush_i = 1'b0; f_ack = 1'b1;
    chk("flush_cyc_drop", wb_cyc_o, 1'b0);
    @(negedge wb_clk_i);
    chk("flush_no_err", bus_err_o, 1'b0);
    chk("flush_stb_drop", wb_stb_o, 1'b0);
    @(posedge wb_clk_i); #1;
    f_ack = 1'b0;
    chk("late_ack_no_cycle", wb_cyc_o, 1'b0);
    chk("late_ack_no_err", bus_err_o, 1'b0);
    cpu_ce_i = 1'b1; flush_i = 1'b1;
    @(negedge wb_clk_i) chk("idle_flush_stallreq", stallreq_o, 1'b0);
    @(posedge wb_clk_i); #1;
    chk("idle_flush_no_start", wb_cyc_o, 1'b0);
    cpu_ce_i = 1'b0; flush_i = 1'b0;

    run_txn(1'b0, 32'h0300_0000, 32'h0, 4'hF, 2, 0, 0, 1'b0);
    run_txn(1'b0, 32'h0300_0004, 32'h0, 4'hF, 1, 1, 0, 1'b0);

    // Asynchronous reset between clock edges while BUSY.
    s_mode = 2;
    cpu_we_i = 1'b0; cpu_addr_i = 32'h0200_0020; cpu_ce_i = 1'b1;
    @(posedge wb_clk_i); #1;
    cpu_ce_i = 1'b0;
    #2 wb_rst_i = 1'b0;
    #1;
    chk("arst_cyc", wb_cyc_o, 1'b0);
    chk("arst_stb", wb_stb_o, 1'b0);
    chk("arst_stallreq", stallreq_o, 1'b0);
    @(negedge wb_clk_i); #2;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    run_txn(1'b0, 32'h0200_BFF8, 32'h0, 4'hF, 0, 2, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      bit          we;
      logic [31:0] a, d;
      logic [3:0]  sel;
      int          mode, lat, nst;
      we   = 1'($urandom_range(0, 1));
      a    = 32'h0200_0000 + 32'($urandom_range(0, 7) * 4);
      d    = $urandom;
      sel  = 4'($urandom_range(1, 15));
      mode = ($urandom_range(0, 9) == 0) ? 1 : 0;
      lat  = $urandom_range(0, 3);
      nst  = (mode == 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_txn(we, a, d, sel, mode, lat, nst, 1'b0);
    end

    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
